// File: rtl/stride_decoder.sv
// ---------------------------------------------------------------------------
// stride_decoder
//
// Purpose:
//   Receiver end of the stride-instruction interface. It accepts one
//   conv-stride instruction, which is one output pixel across all output
//   channels. For each output channel it walks ci x ky x kx and issues
//   paired feature/kernel read addresses to the MAC datapath. An optional
//   bias read follows each channel's taps, and each channel ends with one
//   writeback request. inst_done pulses once the whole instruction retires.
//
// Ports:
//   clk, rst_n                  clock, asynchronous active-low reset
//   inst_valid / decoder_ready  instruction handshake (fields below latched)
//   stride_*                    instruction fields (bases, dimensions, flags)
//   rd_valid / rd_ready         read-request handshake to the MAC datapath
//   rd_faddr, rd_kaddr          feature / kernel BRAM word addresses
//   rd_first, rd_last, rd_bias  per-request markers for the accumulator
//   wb_valid / wb_ready         writeback-request handshake
//   wb_addr, wb_relu            writeback address and ReLU enable
//   inst_done                   one-cycle pulse when the instruction retires
// ---------------------------------------------------------------------------
module stride_decoder #(
    parameter int FRAM_AW = 12,
    parameter int KRAM_AW = 12,
    parameter int DW      = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               inst_valid,
    output logic               decoder_ready,
    input  logic [FRAM_AW-1:0] stride_feature_baseaddr,
    input  logic [KRAM_AW-1:0] stride_kernel_baseaddr,
    input  logic [DW-1:0]      stride_feature_chin,
    input  logic [DW-1:0]      stride_feature_chout,
    input  logic [DW-1:0]      stride_feature_width,
    input  logic [DW-1:0]      stride_feature_height,
    input  logic [DW-1:0]      stride_kernel_sizeh,
    input  logic [DW-1:0]      stride_kernel_sizew,
    input  logic               stride_has_bias,
    input  logic               stride_has_relu,
    input  logic [FRAM_AW-1:0] stride_wb_baseaddr,
    input  logic [DW-1:0]      stride_wb_ch_offset,
    output logic               rd_valid,
    input  logic               rd_ready,
    output logic [FRAM_AW-1:0] rd_faddr,
    output logic [KRAM_AW-1:0] rd_kaddr,
    output logic               rd_first,
    output logic               rd_last,
    output logic               rd_bias,
    output logic               wb_valid,
    input  logic               wb_ready,
    output logic [FRAM_AW-1:0] wb_addr,
    output logic               wb_relu,
    output logic               inst_done
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_SETUP = 3'd1;
    localparam logic [2:0] S_TAP   = 3'd2;
    localparam logic [2:0] S_BIAS  = 3'd3;
    localparam logic [2:0] S_WB    = 3'd4;
    localparam logic [2:0] S_DONE  = 3'd5;

    localparam logic [DW-1:0]      ONE_DW = {{(DW-1){1'b0}}, 1'b1};
    localparam logic [FRAM_AW-1:0] ONE_FA = {{(FRAM_AW-1){1'b0}}, 1'b1};
    localparam logic [KRAM_AW-1:0] ONE_KA = {{(KRAM_AW-1){1'b0}}, 1'b1};

    logic [2:0]         state;

    // Latched instruction fields. Address-domain quantities are kept at
    // address width because all address arithmetic wraps there anyway.
    logic [DW-1:0]      chin_q;
    logic [DW-1:0]      chout_q;
    logic [DW-1:0]      kh_q;
    logic [DW-1:0]      kw_q;
    logic [FRAM_AW-1:0] fbase_q;
    logic [FRAM_AW-1:0] width_q;
    logic [FRAM_AW-1:0] ch_flat_q;
    logic [KRAM_AW-1:0] kstride_q;
    logic [FRAM_AW-1:0] wb_off_q;
    logic               bias_q;
    logic               relu_q;

    // Loop counters, kx innermost.
    logic [DW-1:0]      co;
    logic [DW-1:0]      ci;
    logic [DW-1:0]      ky;
    logic [DW-1:0]      kx;

    // Incrementally maintained address bases.
    logic [FRAM_AW-1:0] f_ch;
    logic [FRAM_AW-1:0] f_row;
    logic [FRAM_AW-1:0] faddr;
    logic [KRAM_AW-1:0] k_ch;
    logic [KRAM_AW-1:0] kaddr;
    logic [FRAM_AW-1:0] wb_addr_q;

    logic               kx_last;
    logic               ky_last;
    logic               ci_last;
    logic               co_last;
    logic               tap_last;
    logic               rd_fire;
    logic               wb_fire;
    logic               degenerate;

    assign kx_last    = (kx == kw_q - ONE_DW);
    assign ky_last    = (ky == kh_q - ONE_DW);
    assign ci_last    = (ci == chin_q - ONE_DW);
    assign co_last    = (co == chout_q - ONE_DW);
    assign tap_last   = kx_last && ky_last && ci_last;
    assign degenerate = (chin_q == '0) || (chout_q == '0) ||
                        (kh_q == '0) || (kw_q == '0);

    assign rd_fire = rd_valid && rd_ready;
    assign wb_fire = wb_valid && wb_ready;

    // All request outputs come straight from registers and the state, so
    // they hold still for as long as the consumer stalls.
    assign decoder_ready = (state == S_IDLE);
    assign rd_valid      = (state == S_TAP) || (state == S_BIAS);
    assign rd_bias       = (state == S_BIAS);
    assign rd_first      = (state == S_TAP) && (ci == '0) && (ky == '0) && (kx == '0);
    assign rd_last       = ((state == S_TAP) && tap_last && !bias_q) || (state == S_BIAS);
    assign rd_faddr      = faddr;
    assign rd_kaddr      = kaddr;
    assign wb_valid      = (state == S_WB);
    assign wb_addr       = wb_addr_q;
    assign wb_relu       = (state == S_WB) && relu_q;
    assign inst_done     = (state == S_DONE);

    // Control FSM. The kernel offset (ci*kh+ky)*kw+kx is the linear tap
    // index, so kaddr simply counts up by one per read; after the last tap
    // it already points at the bias word, and the next channel starts one
    // kstride further on.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            chin_q    <= '0;
            chout_q   <= '0;
            kh_q      <= '0;
            kw_q      <= '0;
            fbase_q   <= '0;
            width_q   <= '0;
            ch_flat_q <= '0;
            kstride_q <= '0;
            wb_off_q  <= '0;
            bias_q    <= 1'b0;
            relu_q    <= 1'b0;
            co        <= '0;
            ci        <= '0;
            ky        <= '0;
            kx        <= '0;
            f_ch      <= '0;
            f_row     <= '0;
            faddr     <= '0;
            k_ch      <= '0;
            kaddr     <= '0;
            wb_addr_q <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (inst_valid) begin
                        state     <= S_SETUP;
                        chin_q    <= stride_feature_chin;
                        chout_q   <= stride_feature_chout;
                        kh_q      <= stride_kernel_sizeh;
                        kw_q      <= stride_kernel_sizew;
                        fbase_q   <= stride_feature_baseaddr;
                        width_q   <= FRAM_AW'(stride_feature_width);
                        ch_flat_q <= FRAM_AW'(stride_feature_width * stride_feature_height);
                        kstride_q <= KRAM_AW'(stride_feature_chin * stride_kernel_sizeh *
                                              stride_kernel_sizew +
                                              {{(DW-1){1'b0}}, stride_has_bias});
                        wb_off_q  <= FRAM_AW'(stride_wb_ch_offset);
                        bias_q    <= stride_has_bias;
                        relu_q    <= stride_has_relu;
                        co        <= '0;
                        ci        <= '0;
                        ky        <= '0;
                        kx        <= '0;
                        f_ch      <= stride_feature_baseaddr;
                        f_row     <= stride_feature_baseaddr;
                        faddr     <= stride_feature_baseaddr;
                        k_ch      <= stride_kernel_baseaddr;
                        kaddr     <= stride_kernel_baseaddr;
                        wb_addr_q <= stride_wb_baseaddr;
                    end
                end
                S_SETUP: begin
                    state <= degenerate ? S_DONE : S_TAP;
                end
                S_TAP: begin
                    if (rd_fire) begin
                        kaddr <= kaddr + ONE_KA;
                        if (tap_last) begin
                            state <= bias_q ? S_BIAS : S_WB;
                        end else if (!kx_last) begin
                            kx    <= kx + ONE_DW;
                            faddr <= faddr + ONE_FA;
                        end else if (!ky_last) begin
                            kx    <= '0;
                            ky    <= ky + ONE_DW;
                            f_row <= f_row + width_q;
                            faddr <= f_row + width_q;
                        end else begin
                            kx    <= '0;
                            ky    <= '0;
                            ci    <= ci + ONE_DW;
                            f_ch  <= f_ch + ch_flat_q;
                            f_row <= f_ch + ch_flat_q;
                            faddr <= f_ch + ch_flat_q;
                        end
                    end
                end
                S_BIAS: begin
                    if (rd_fire) begin
                        state <= S_WB;
                    end
                end
                S_WB: begin
                    if (wb_fire) begin
                        if (co_last) begin
                            state <= S_DONE;
                        end else begin
                            state     <= S_TAP;
                            co        <= co + ONE_DW;
                            ci        <= '0;
                            ky        <= '0;
                            kx        <= '0;
                            f_ch      <= fbase_q;
                            f_row     <= fbase_q;
                            faddr     <= fbase_q;
                            k_ch      <= k_ch + kstride_q;
                            kaddr     <= k_ch + kstride_q;
                            wb_addr_q <= wb_addr_q + wb_off_q;
                        end
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_stride_decoder.sv
// ---------------------------------------------------------------------------
// tb_stride_decoder
//
// Purpose:
//   Self-checking bench for stride_decoder. A behavioural model expands each
//   instruction into the expected read and writeback sequences using the
//   closed-form address formulas. A per-cycle compare step checks every
//   handshake, stall stability and the busy/done behaviour against that
//   model. Literal address lists pin the model for the directed cases.
//
// Ports: none (top-level bench).
// ---------------------------------------------------------------------------
module tb_stride_decoder;

    localparam int FAW = 12;
    localparam int KAW = 12;
    localparam int DW  = 32;

    logic           clk;
    logic           rst_n;
    logic           inst_valid;
    logic           decoder_ready;
    logic [FAW-1:0] fbase;
    logic [KAW-1:0] kbase;
    logic [DW-1:0]  chin;
    logic [DW-1:0]  chout;
    logic [DW-1:0]  width;
    logic [DW-1:0]  height;
    logic [DW-1:0]  kh;
    logic [DW-1:0]  kw;
    logic           has_bias;
    logic           has_relu;
    logic [FAW-1:0] wb_base;
    logic [DW-1:0]  wb_off;
    logic           rd_valid;
    logic           rd_ready;
    logic [FAW-1:0] rd_faddr;
    logic [KAW-1:0] rd_kaddr;
    logic           rd_first;
    logic           rd_last;
    logic           rd_bias;
    logic           wb_valid;
    logic           wb_ready;
    logic [FAW-1:0] wb_addr;
    logic           wb_relu;
    logic           inst_done;

    stride_decoder #(.FRAM_AW(FAW), .KRAM_AW(KAW), .DW(DW)) dut (
        .clk                     (clk),
        .rst_n                   (rst_n),
        .inst_valid              (inst_valid),
        .decoder_ready           (decoder_ready),
        .stride_feature_baseaddr (fbase),
        .stride_kernel_baseaddr  (kbase),
        .stride_feature_chin     (chin),
        .stride_feature_chout    (chout),
        .stride_feature_width    (width),
        .stride_feature_height   (height),
        .stride_kernel_sizeh     (kh),
        .stride_kernel_sizew     (kw),
        .stride_has_bias         (has_bias),
        .stride_has_relu         (has_relu),
        .stride_wb_baseaddr      (wb_base),
        .stride_wb_ch_offset     (wb_off),
        .rd_valid                (rd_valid),
        .rd_ready                (rd_ready),
        .rd_faddr                (rd_faddr),
        .rd_kaddr                (rd_kaddr),
        .rd_first                (rd_first),
        .rd_last                 (rd_last),
        .rd_bias                 (rd_bias),
        .wb_valid                (wb_valid),
        .wb_ready                (wb_ready),
        .wb_addr                 (wb_addr),
        .wb_relu                 (wb_relu),
        .inst_done               (inst_done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        int faddr;
        int kaddr;
        bit first;
        bit last;
        bit bias;
    } rd_t;

    int   checks = 0;
    int   errors = 0;

    // Current instruction configuration (model input).
    int   cFbase, cKbase, cChin, cChout, cW, cH, cKh, cKw, cBias, cRelu, cWb, cWbOff;

    // Expected sequences and observed logs.
    rd_t  rdQ[$];
    int   wbQ[$];
    int   fLog[$];
    int   kLog[$];
    bit   firstLog[$];
    bit   lastLog[$];
    bit   biasLog[$];
    int   wbLog[$];
    bit   reluLog[$];

    // Stall tracking and instruction lifecycle.
    bit             busy;
    bit             doneSeen;
    int             doneTick;
    int             tickNo;
    int             cyc;
    bit             rdToggle;
    int             wbDelay;
    int             wbWait;
    logic [3:0]     rdPattern;
    bit             rdStall;
    logic [FAW-1:0] sFaddr;
    logic [KAW-1:0] sKaddr;
    logic           sFirst, sLast, sBias;
    bit             wbStall;
    logic [FAW-1:0] sWbAddr;
    logic           sWbRelu;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic setCfg(input int fb, input int kb, input int ci, input int co,
                          input int w, input int h, input int khv, input int kwv,
                          input int b, input int r, input int wbb, input int wbo);
        cFbase = fb; cKbase = kb; cChin = ci; cChout = co; cW = w; cH = h;
        cKh = khv; cKw = kwv; cBias = b; cRelu = r; cWb = wbb; cWbOff = wbo;
    endtask

    // Model: expand the instruction with the closed-form address formulas.
    task automatic buildExpected();
        rd_t e;
        int  kst;
        rdQ.delete();
        wbQ.delete();
        if (cChin == 0 || cChout == 0 || cKh == 0 || cKw == 0) return;
        kst = cChin * cKh * cKw + cBias;
        for (int co = 0; co < cChout; co++) begin
            for (int ci = 0; ci < cChin; ci++)
                for (int ky = 0; ky < cKh; ky++)
                    for (int kx = 0; kx < cKw; kx++) begin
                        e.faddr = cFbase + ci * cW * cH + ky * cW + kx;
                        e.kaddr = cKbase + co * kst + (ci * cKh + ky) * cKw + kx;
                        e.first = (ci == 0 && ky == 0 && kx == 0);
                        e.last  = (cBias == 0) && (ci == cChin - 1) &&
                                  (ky == cKh - 1) && (kx == cKw - 1);
                        e.bias  = 1'b0;
                        rdQ.push_back(e);
                    end
            if (cBias != 0) begin
                e.faddr = 0;
                e.kaddr = cKbase + co * kst + cChin * cKh * cKw;
                e.first = 1'b0;
                e.last  = 1'b1;
                e.bias  = 1'b1;
                rdQ.push_back(e);
            end
            wbQ.push_back(cWb + co * cWbOff);
        end
    endtask

    // Per-cycle comparison of DUT outputs against the model.
    task automatic compareCycle();
        rd_t e;
        if (!rst_n) begin
            busy    = 1'b0;
            rdStall = 1'b0;
            wbStall = 1'b0;
            return;
        end
        if (!busy) begin
            checkOutput("idle_rd_valid", rd_valid, 0);
            checkOutput("idle_wb_valid", wb_valid, 0);
            checkOutput("idle_inst_done", inst_done, 0);
            checkOutput("idle_decoder_ready", decoder_ready, 1);
            return;
        end
        checkOutput("busy_decoder_ready", decoder_ready, 0);
        if (rdStall) begin
            checkOutput("stall_rd_valid", rd_valid, 1);
            if (!sBias) checkOutput("stall_rd_faddr", rd_faddr, sFaddr);
            checkOutput("stall_rd_kaddr", rd_kaddr, sKaddr);
            checkOutput("stall_rd_first", rd_first, sFirst);
            checkOutput("stall_rd_last", rd_last, sLast);
            checkOutput("stall_rd_bias", rd_bias, sBias);
        end
        if (wbStall) begin
            checkOutput("stall_wb_valid", wb_valid, 1);
            checkOutput("stall_wb_addr", wb_addr, sWbAddr);
            checkOutput("stall_wb_relu", wb_relu, sWbRelu);
        end
        if (rd_valid && rd_ready) begin
            if (rdQ.size() == 0) begin
                checkOutput("unexpected_read", 1, 0);
            end else begin
                e = rdQ.pop_front();
                if (!e.bias) checkOutput("rd_faddr", rd_faddr, FAW'(e.faddr));
                checkOutput("rd_kaddr", rd_kaddr, KAW'(e.kaddr));
                checkOutput("rd_first", rd_first, e.first);
                checkOutput("rd_last", rd_last, e.last);
                checkOutput("rd_bias", rd_bias, e.bias);
            end
            fLog.push_back(int'(rd_faddr));
            kLog.push_back(int'(rd_kaddr));
            firstLog.push_back(rd_first);
            lastLog.push_back(rd_last);
            biasLog.push_back(rd_bias);
        end
        if (wb_valid && wb_ready) begin
            if (wbQ.size() == 0) begin
                checkOutput("unexpected_wb", 1, 0);
            end else begin
                checkOutput("wb_addr", wb_addr, FAW'(wbQ.pop_front()));
                checkOutput("wb_relu", wb_relu, cRelu);
            end
            wbLog.push_back(int'(wb_addr));
            reluLog.push_back(wb_relu);
        end
        if (inst_done) begin
            checkOutput("done_reads_left", rdQ.size(), 0);
            checkOutput("done_wbs_left", wbQ.size(), 0);
            busy     = 1'b0;
            doneSeen = 1'b1;
            doneTick = tickNo;
        end
        rdStall = rd_valid && !rd_ready;
        sFaddr  = rd_faddr;
        sKaddr  = rd_kaddr;
        sFirst  = rd_first;
        sLast   = rd_last;
        sBias   = rd_bias;
        wbStall = wb_valid && !wb_ready;
        sWbAddr = wb_addr;
        sWbRelu = wb_relu;
    endtask

    // One clock: drive ready inputs after the edge, compare at the falling edge.
    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        tickNo++;
        if (inst_valid) begin
            inst_valid = 1'b0;
            fbase      = FAW'($urandom);
            kbase      = KAW'($urandom);
            chin       = $urandom;
            chout      = $urandom;
            width      = $urandom;
            height     = $urandom;
            kh         = $urandom;
            kw         = $urandom;
            has_bias   = 1'($urandom);
            has_relu   = 1'($urandom);
            wb_base    = FAW'($urandom);
            wb_off     = $urandom;
        end
        rd_ready = rdToggle ? rdPattern[cyc % 4] : 1'b1;
        if (wb_valid) wbWait++; else wbWait = 0;
        wb_ready = (wbWait > wbDelay);
        @(negedge clk);
        compareCycle();
    endtask

    task automatic applyStimulus();
        fbase    = FAW'(cFbase);
        kbase    = KAW'(cKbase);
        chin     = DW'(cChin);
        chout    = DW'(cChout);
        width    = DW'(cW);
        height   = DW'(cH);
        kh       = DW'(cKh);
        kw       = DW'(cKw);
        has_bias = cBias[0];
        has_relu = cRelu[0];
        wb_base  = FAW'(cWb);
        wb_off   = DW'(cWbOff);
        buildExpected();
        fLog.delete(); kLog.delete(); firstLog.delete(); lastLog.delete();
        biasLog.delete(); wbLog.delete(); reluLog.delete();
        checkOutput("ready_before_accept", decoder_ready, 1);
        inst_valid = 1'b1;
        busy       = 1'b1;
        doneSeen   = 1'b0;
        doneTick   = 0;
        tickNo     = 0;
    endtask

    task automatic waitDone(input int budget);
        for (int i = 0; i < budget && !doneSeen; i++) tick();
        checkOutput("done_within_budget", doneSeen, 1);
        tick();
    endtask

    // Pins the model and DUT to the hand-derived sequence of case 1.
    task automatic checkCase1Literal(input string tag);
        int expF[8];
        expF = '{10, 11, 14, 15, 26, 27, 30, 31};
        checkOutput({tag, "_read_count"}, fLog.size(), 8);
        for (int i = 0; i < 8 && i < fLog.size(); i++) begin
            checkOutput($sformatf("%s_faddr%0d", tag, i), fLog[i], expF[i]);
            checkOutput($sformatf("%s_kaddr%0d", tag, i), kLog[i], i);
            checkOutput($sformatf("%s_first%0d", tag, i), firstLog[i], (i == 0));
            checkOutput($sformatf("%s_last%0d", tag, i), lastLog[i], (i == 7));
        end
        checkOutput({tag, "_wb_count"}, wbLog.size(), 1);
        if (wbLog.size() > 0) checkOutput({tag, "_wb_addr"}, wbLog[0], 100);
    endtask

    initial begin
        rst_n      = 1'b0;
        inst_valid = 1'b0;
        rd_ready   = 1'b0;
        wb_ready   = 1'b0;
        fbase = '0; kbase = '0; chin = '0; chout = '0; width = '0; height = '0;
        kh = '0; kw = '0; has_bias = 1'b0; has_relu = 1'b0; wb_base = '0; wb_off = '0;
        busy = 1'b0; doneSeen = 1'b0; doneTick = 0; tickNo = 0; cyc = 0;
        rdToggle = 1'b0; wbDelay = 0; wbWait = 0; rdPattern = 4'b1001;
        rdStall = 1'b0; wbStall = 1'b0;
        sFaddr = '0; sKaddr = '0; sFirst = 1'b0; sLast = 1'b0; sBias = 1'b0;
        sWbAddr = '0; sWbRelu = 1'b0;

        #12;
        $display("[TB] reset state");
        checkOutput("reset_decoder_ready", decoder_ready, 1);
        checkOutput("reset_rd_valid", rd_valid, 0);
        checkOutput("reset_wb_valid", wb_valid, 0);
        checkOutput("reset_inst_done", inst_done, 0);
        checkOutput("reset_rd_faddr", rd_faddr, 0);
        checkOutput("reset_wb_addr", wb_addr, 0);
        rst_n = 1'b1;
        tick();

        $display("[TB] case 1: basic 2x2 kernel, two input channels");
        setCfg(10, 0, 2, 1, 4, 4, 2, 2, 0, 0, 100, 0);
        applyStimulus();
        waitDone(200);
        checkCase1Literal("c1");

        $display("[TB] case 2: two output channels with bias");
        setCfg(10, 0, 2, 2, 4, 4, 2, 2, 1, 0, 100, 16);
        applyStimulus();
        waitDone(200);
        checkOutput("c2_read_count", kLog.size(), 18);
        for (int i = 0; i < 18 && i < kLog.size(); i++) begin
            checkOutput($sformatf("c2_kaddr%0d", i), kLog[i], i);
            checkOutput($sformatf("c2_bias%0d", i), biasLog[i], (i == 8 || i == 17));
        end
        checkOutput("c2_wb_count", wbLog.size(), 2);
        if (wbLog.size() == 2) begin
            checkOutput("c2_wb0", wbLog[0], 100);
            checkOutput("c2_wb1", wbLog[1], 116);
        end

        $display("[TB] case 3: backpressure on reads and writeback");
        rdToggle = 1'b1;
        wbDelay  = 3;
        setCfg(10, 0, 2, 1, 4, 4, 2, 2, 0, 0, 100, 0);
        applyStimulus();
        waitDone(400);
        checkCase1Literal("c3");
        rdToggle = 1'b0;
        wbDelay  = 0;

        $display("[TB] case 4: degenerate instruction");
        setCfg(10, 0, 0, 2, 4, 4, 2, 2, 0, 0, 100, 0);
        applyStimulus();
        waitDone(20);
        checkOutput("c4_done_tick", doneTick, 2);
        checkOutput("c4_reads", fLog.size(), 0);
        checkOutput("c4_wbs", wbLog.size(), 0);

        $display("[TB] case 5: single-tap channels with relu");
        setCfg(5, 20, 1, 3, 4, 4, 1, 1, 0, 1, 200, 1);
        applyStimulus();
        waitDone(100);
        checkOutput("c5_read_count", fLog.size(), 3);
        for (int i = 0; i < 3 && i < fLog.size(); i++) begin
            checkOutput($sformatf("c5_first_last%0d", i), firstLog[i] && lastLog[i], 1);
            checkOutput($sformatf("c5_faddr%0d", i), fLog[i], 5);
            checkOutput($sformatf("c5_kaddr%0d", i), kLog[i], 20 + i);
        end
        checkOutput("c5_wb_count", wbLog.size(), 3);
        for (int i = 0; i < 3 && i < wbLog.size(); i++) begin
            checkOutput($sformatf("c5_wb_addr%0d", i), wbLog[i], 200 + i);
            checkOutput($sformatf("c5_relu%0d", i), reluLog[i], 1);
        end

        $display("[TB] case 6: reset during taps");
        setCfg(10, 0, 2, 1, 4, 4, 2, 2, 0, 0, 100, 0);
        applyStimulus();
        for (int i = 0; i < 30 && fLog.size() < 4; i++) tick();
        checkOutput("c6_reached_taps", fLog.size(), 4);
        rst_n = 1'b0;
        #1;
        checkOutput("c6_rst_rd_valid", rd_valid, 0);
        checkOutput("c6_rst_wb_valid", wb_valid, 0);
        checkOutput("c6_rst_inst_done", inst_done, 0);
        checkOutput("c6_rst_decoder_ready", decoder_ready, 1);
        tick();
        tick();
        rst_n = 1'b1;
        rdQ.delete();
        wbQ.delete();
        tick();
        checkOutput("c6_ready_after_release", decoder_ready, 1);
        applyStimulus();
        waitDone(200);
        checkCase1Literal("c6");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/stride_decoder.md
Name: stride_decoder

Overview:
Receiver end of the stride-instruction interface (inst_valid/decoder_ready). It accepts one conv-stride instruction, which is one output pixel across all output channels. It then walks chout × chin × kh × kw and issues paired feature-RAM/kernel-RAM read addresses to the MAC datapath, with an optional bias fetch per output channel. After each output channel it issues one writeback request. It sits between the instruction generator and the BRAM/MAC/writeback path.

Parameters:
FRAM_AW, 12, feature BRAM word-address width
KRAM_AW, 12, kernel BRAM word-address width
DW, 32, width of dimension/count fields

Ports:
clk  in  1  clock
rst_n  in  1  async active-low reset
inst_valid  in  1  instruction valid
decoder_ready  out  1  ready to accept instruction
stride_feature_baseaddr  in  FRAM_AW  feature address of window top-left, channel 0
stride_kernel_baseaddr  in  KRAM_AW  kernel base address
stride_feature_chin  in  DW  input channels
stride_feature_chout  in  DW  output channels
stride_feature_width  in  DW  feature width
stride_feature_height  in  DW  feature height
stride_kernel_sizeh  in  DW  kernel height
stride_kernel_sizew  in  DW  kernel width
stride_has_bias  in  1  bias word follows each output channel's weights
stride_has_relu  in  1  apply ReLU at writeback
stride_wb_baseaddr  in  FRAM_AW  writeback address, output channel 0
stride_wb_ch_offset  in  DW  writeback address step per output channel
rd_valid  out  1  read request valid
rd_ready  in  1  datapath accepts read request
rd_faddr  out  FRAM_AW  feature read address
rd_kaddr  out  KRAM_AW  kernel read address
rd_first  out  1  first tap of output channel (clear accumulator)
rd_last  out  1  last read of output channel
rd_bias  out  1  this read is the bias word (rd_faddr don't-care)
wb_valid  out  1  writeback request
wb_ready  in  1  writeback accepted
wb_addr  out  FRAM_AW  writeback address
wb_relu  out  1  ReLU enable for this writeback
inst_done  out  1  one-cycle pulse when instruction fully retired

Behaviour:
- Reset: state IDLE, all counters 0, and all outputs 0 except decoder_ready. Reset mid-operation aborts immediately and issues no further requests.
- decoder_ready = (state==IDLE). Accept on inst_valid&&decoder_ready; latch all fields.
- Precompute at accept: ch_flat = width*height and kstride = chin*kh*kw + has_bias. Address arithmetic truncates to FRAM_AW/KRAM_AW; wrap-around is permitted, not flagged.
- States:
  - IDLE → SETUP on accept.
  - SETUP (1 cycle):
    - if any of chin, chout, kh, kw is 0 → DONE (degenerate instruction; no reads, no writebacks);
    - else → TAP with co=ci=ky=kx=0.
  - TAP: rd_valid=1.
    - rd_faddr = fbase + ci*ch_flat + ky*width + kx.
    - rd_kaddr = kbase + co*kstride + ((ci*kh+ky)*kw + kx).
    - Build both addresses from incrementally maintained row/channel base registers; no per-cycle multiplier.
    - Counters advance only on rd_valid&&rd_ready, with kx innermost, then ky, then ci.
    - rd_first=1 on the tap with ci=ky=kx=0.
    - On the last tap: rd_last=1 if !has_bias; next state is BIAS if has_bias, else WB.
  - BIAS: rd_valid=1, rd_bias=1, rd_last=1, rd_kaddr = kbase + co*kstride + chin*kh*kw. On handshake → WB.
  - WB: wb_valid=1, wb_addr = wb_base + co*wb_ch_offset, wb_relu = latched has_relu. On wb_valid&&wb_ready:
    - co==chout-1 → DONE;
    - else co++, reset ci/ky/kx → TAP.
  - DONE: inst_done=1 for one cycle → IDLE.
- Outputs hold stable while valid && !ready. No request is dropped or duplicated under any backpressure pattern.
- Single-tap channel (chin=kh=kw=1, no bias): rd_first and rd_last assert on the same request.
- Throughput: one read per cycle with rd_ready held high. Overhead per output channel: 1 WB cycle, plus 1 BIAS cycle when has_bias. Per instruction: 1 SETUP and 1 DONE cycle.
- Inputs are ignored outside the accept cycle.

Test Plan:
1. W=H=4, chin=2, chout=1, kh=kw=2, fbase=10, kbase=0, wb_base=100, no bias, rd_ready=1:
   - rd_faddr 10,11,14,15,26,27,30,31;
   - rd_kaddr 0..7;
   - rd_first on read 1, rd_last on read 8;
   - then wb_addr=100, then inst_done.
2. Same as 1 but chout=2, has_bias=1, wb_ch_offset=16:
   - ch0 kaddr 0..7, then bias kaddr 8 (rd_bias, rd_last);
   - ch1 kaddr 9..16, bias 17;
   - wb_addr 100 then 116.
3. Case 1 with rd_ready toggling 1,0,0,1 repeatedly and wb_ready delayed 3 cycles:
   - identical address sequence;
   - outputs stable while stalled;
   - decoder_ready low until after inst_done.
4. chin=0 → accepted, no rd_valid/wb_valid, inst_done pulse 2 cycles after accept. Next instruction is accepted normally.
5. chin=kh=kw=1, chout=3, relu=1 → each read has rd_first=rd_last=1; three writebacks each with wb_relu=1.
6. Assert rst_n low during TAP of case 1 → all valids drop immediately, decoder_ready=1 after release, and a fresh instruction runs the correct full sequence.
